// File: rtl/pix_scale_ctrl.sv
// Sequencing controller for the rational pixel upscaler: schedules input shifts and output
// issues for an UP_COEF/LOW_COEF ratio with a two-pixel interpolation window.
module pix_scale_ctrl #(
    parameter int unsigned UP_COEF     = 3,
    parameter int unsigned LOW_COEF    = 2,
    parameter int unsigned LINE_IN     = 640,
    parameter int unsigned FRAME_LINES = 480,
    localparam int unsigned PW = (UP_COEF > 1) ? $clog2(UP_COEF) : 1
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          enable,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] phase,
    output logic          out_edge,
    output logic          out_last,
    output logic          frame_done,
    output logic          busy
);

    localparam int unsigned N_OUT = LINE_IN * UP_COEF / LOW_COEF;
    localparam int unsigned IW    = $clog2(LINE_IN + 1);
    localparam int unsigned KW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned LW    = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] n_in_q, n_in_d;
    logic [KW-1:0] k_q, k_d;
    logic [LW-1:0] line_q, line_d;
    logic          frame_done_q, frame_done_d;

    logic          active;
    logic [IW:0]   idx_p2;
    logic [IW:0]   need;
    logic          at_edge;
    logic          at_last;
    logic          out_fire;
    logic [PW:0]   acc_sum;

    // Window needs idx and idx+1, clamped at the line end where the edge pixel is replicated.
    always_comb begin
        active    = (state_q == StRun) && enable;
        idx_p2    = {1'b0, idx_q} + (IW + 1)'(2);
        need      = (idx_p2 > (IW + 1)'(LINE_IN)) ? (IW + 1)'(LINE_IN) : idx_p2;
        in_ready  = active && ({1'b0, n_in_q} < need);
        out_valid = active && ({1'b0, n_in_q} == need);
        shift_en  = in_ready && in_valid;
        out_fire  = out_valid && out_ready;
        at_edge   = (idx_q == IW'(LINE_IN - 1));
        at_last   = (k_q == KW'(N_OUT - 1));
        phase     = out_valid ? acc_q : '0;
        out_edge  = out_valid && at_edge;
        out_last  = out_valid && at_last;
        busy      = (state_q == StRun);
        frame_done = frame_done_q;
        acc_sum   = {1'b0, acc_q} + (PW + 1)'(LOW_COEF);
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        n_in_d       = n_in_q;
        k_d          = k_q;
        line_d       = line_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (shift_en) begin
                    n_in_d = n_in_q + 1'b1;
                end
                if (out_fire) begin
                    // LOW_COEF <= UP_COEF, so the accumulator wraps at most once per output.
                    if (acc_sum >= (PW + 1)'(UP_COEF)) begin
                        acc_d = PW'(acc_sum - (PW + 1)'(UP_COEF));
                        idx_d = idx_q + 1'b1;
                    end else begin
                        acc_d = acc_sum[PW-1:0];
                    end
                    k_d = k_q + 1'b1;
                    if (at_last) begin
                        acc_d  = '0;
                        idx_d  = '0;
                        n_in_d = '0;
                        k_d    = '0;
                        if (line_q == LW'(FRAME_LINES - 1)) begin
                            line_d       = '0;
                            frame_done_d = 1'b1;
                            state_d      = StIdle;
                        end else begin
                            line_d = line_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            idx_q        <= '0;
            n_in_q       <= '0;
            k_q          <= '0;
            line_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            n_in_q       <= n_in_d;
            k_q          <= k_d;
            line_q       <= line_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_pix_scale_ctrl.sv
// Bench for pix_scale_ctrl: event-count model checked every cycle, plus directed literal checks
// for a 3/2 instance (LINE_IN=4, 2 lines) and an identity 2/2 instance.
module tb_pix_scale_ctrl;

    localparam int TUP   = 3;
    localparam int TLOW  = 2;
    localparam int TLINE = 4;
    localparam int TFR   = 2;
    localparam int TNOUT = TLINE * TUP / TLOW;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, shift_en, out_valid, out_edge, out_last, frame_done, busy;
    logic [1:0] phase;

    logic       start2 = 1'b0;
    logic       in_valid2 = 1'b0;
    logic       out_ready2 = 1'b0;
    logic       in_ready2, shift_en2, out_valid2, out_edge2, out_last2, frame_done2, busy2;
    logic [0:0] phase2;

    always #5 clk_in = ~clk_in;

    pix_scale_ctrl #(
        .UP_COEF(TUP), .LOW_COEF(TLOW), .LINE_IN(TLINE), .FRAME_LINES(TFR)
    ) dut (
        .clk_in(clk_in), .rst(rst), .enable(enable), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .shift_en(shift_en), .out_valid(out_valid),
        .out_ready(out_ready), .phase(phase), .out_edge(out_edge), .out_last(out_last),
        .frame_done(frame_done), .busy(busy)
    );

    pix_scale_ctrl #(
        .UP_COEF(2), .LOW_COEF(2), .LINE_IN(4), .FRAME_LINES(2)
    ) dut_id (
        .clk_in(clk_in), .rst(rst), .enable(1'b1), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .shift_en(shift_en2), .out_valid(out_valid2),
        .out_ready(out_ready2), .phase(phase2), .out_edge(out_edge2), .out_last(out_last2),
        .frame_done(frame_done2), .busy(busy2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs needed in the line before output j can issue: left index j*LOW/UP plus its neighbour.
    function automatic int need_of(input int j);
        int n;
        n = (j * TLOW) / TUP + 2;
        return (n > TLINE) ? TLINE : n;
    endfunction

    bit m_run = 1'b0;
    int m_nin = 0;
    int m_j = 0;
    int m_line = 0;
    bit m_fd = 1'b0;
    bit chk_on = 1'b0;

    always @(posedge clk_in) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_nin  <= 0;
            m_j    <= 0;
            m_line <= 0;
            m_fd   <= 1'b0;
        end else begin
            m_fd <= 1'b0;
            if (!m_run) begin
                if (start && enable) m_run <= 1'b1;
            end else if (enable) begin
                if (m_nin < need_of(m_j)) begin
                    if (in_valid) m_nin <= m_nin + 1;
                end else if (out_ready) begin
                    if (m_j == TNOUT - 1) begin
                        m_j   <= 0;
                        m_nin <= 0;
                        if (m_line == TFR - 1) begin
                            m_line <= 0;
                            m_run  <= 1'b0;
                            m_fd   <= 1'b1;
                        end else begin
                            m_line <= m_line + 1;
                        end
                    end else begin
                        m_j <= m_j + 1;
                    end
                end
            end
        end
    end

    bit       p_ov = 1'b0;
    bit       p_or = 1'b0;
    bit       p_rst = 1'b1;
    bit [1:0] p_ph = '0;

    always @(negedge clk_in) begin : cmp
        bit act, er, ev;
        if (chk_on) begin
            act = m_run && enable;
            er  = act && (m_nin < need_of(m_j));
            ev  = act && (m_nin == need_of(m_j));
            check("in_ready", in_ready, er);
            check("out_valid", out_valid, ev);
            check("shift_en", shift_en, er && in_valid);
            check("busy", busy, m_run);
            check("frame_done", frame_done, m_fd);
            check("ready_valid_excl", in_ready && out_valid, 0);
            if (ev) begin
                check("phase", phase, (m_j * TLOW) % TUP);
                check("out_edge", out_edge, ((m_j * TLOW) / TUP) == TLINE - 1);
                check("out_last", out_last, m_j == TNOUT - 1);
            end
            if (p_ov && !p_or && !p_rst && enable) begin
                check("valid_held", out_valid, 1);
                check("phase_held", phase, p_ph);
            end
        end
        p_ov  <= out_valid;
        p_or  <= out_ready;
        p_rst <= rst;
        p_ph  <= phase;
    end

    int ph_q[$];
    int ed_q[$];
    int la_q[$];
    int ev_q[$];
    int exp_ph[6] = '{0, 2, 1, 0, 2, 1};
    int exp_ev[10] = '{1, 1, 2, 2, 1, 2, 1, 2, 2, 2};

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_frame(input int stall_at, input bit rnd, output int done_at);
        ph_q.delete();
        ed_q.delete();
        la_q.delete();
        ev_q.delete();
        done_at   = -1;
        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            if (i == 12) start = 1'b1;
            if (i == 13) start = 1'b0;
            if (stall_at >= 0 && i == stall_at) enable = 1'b0;
            if (stall_at >= 0 && i == stall_at + 5) enable = 1'b1;
            if (rnd) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
            if (frame_done) begin
                done_at = i;
                break;
            end
            ev_q.push_back(shift_en ? 1 : ((out_valid && out_ready) ? 2 : 0));
            if (out_valid && out_ready) begin
                ph_q.push_back(int'(phase));
                ed_q.push_back(int'(out_edge));
                la_q.push_back(int'(out_last));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        enable    = 1'b1;
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_nout"}, ph_q.size(), 2 * TNOUT);
        for (int j = 0; j < ph_q.size() && j < 2 * TNOUT; j++) begin
            check($sformatf("%s_phase%0d", tag, j), ph_q[j], exp_ph[j % 6]);
            check($sformatf("%s_edge%0d", tag, j), ed_q[j], (j % 6) == 5);
            check($sformatf("%s_last%0d", tag, j), la_q[j], (j % 6) == 5);
        end
    endtask

    initial begin : stim
        int d;
        int nf;
        int done2;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_phase", phase, 0);
        check("rst_frame_done", frame_done, 0);

        // Streaming frame with a start pulse during RUN.
        run_frame(-1, 1'b0, d);
        check("s2_done_cycle", d, 20);
        check("s2_busy_low", busy, 0);
        for (int i = 0; i < 20 && i < ev_q.size(); i++)
            check($sformatf("s1_event%0d", i), ev_q[i], exp_ev[i % 10]);
        check_seq("s1");
        tick();
        check("s2_frame_done_once", frame_done, 0);

        run_frame(-1, 1'b1, d);
        check("s3_done", d >= 0, 1);
        check_seq("s3");

        run_frame(6, 1'b0, d);
        check("s4_done_cycle", d, 25);
        check_seq("s4");

        // Reset after the fourth output of line 0.
        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nf        = 0;
        for (int i = 0; i < 40 && nf < 4; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            if (out_valid && out_ready) nf++;
        end
        check("s5_reached_out3", nf, 4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_in_ready", in_ready, 0);
        check("s5_out_valid", out_valid, 0);
        check("s5_shift_en", shift_en, 0);
        check("s5_busy", busy, 0);
        check("s5_phase", phase, 0);
        check("s5_out_last", out_last, 0);
        check("s5_frame_done", frame_done, 0);
        run_frame(-1, 1'b0, d);
        check("s5_done_cycle", d, 20);
        check_seq("s5");

        // Identity ratio on the second instance.
        ph_q.delete();
        ed_q.delete();
        la_q.delete();
        done2      = -1;
        start2     = 1'b1;
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 0) start2 = 1'b0;
            if (frame_done2) begin
                done2 = i;
                break;
            end
            check($sformatf("s6_excl%0d", i), in_ready2 && out_valid2, 0);
            if (out_valid2 && out_ready2) begin
                ph_q.push_back(int'(phase2));
                ed_q.push_back(int'(out_edge2));
                la_q.push_back(int'(out_last2));
            end
        end
        check("s6_done_cycle", done2, 16);
        check("s6_nout", ph_q.size(), 8);
        for (int j = 0; j < ph_q.size() && j < 8; j++) begin
            check($sformatf("s6_phase%0d", j), ph_q[j], 0);
            check($sformatf("s6_edge%0d", j), ed_q[j], (j % 4) == 3);
            check($sformatf("s6_last%0d", j), la_q[j], (j % 4) == 3);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
